// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU codes,
// sequencer states, opcode classes and the control-word layout.
package control_sequencer_pkg;

    // 5-bit opcodes taken from ir[31:27]; unlisted codes are illegal
    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,
                           OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,
                           OP_OR   = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8,
                           OP_SHR  = 5'd9,  OP_SHL  = 5'd11, OP_ADDI = 5'd12,
                           OP_ANDI = 5'd13, OP_ORI  = 5'd14, OP_DIV  = 5'd15,
                           OP_MUL  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18,
                           OP_BR   = 5'd19, OP_JR   = 5'd21, OP_MFLO = 5'd24,
                           OP_MFHI = 5'd25, OP_NOP  = 5'd26, OP_HALT = 5'd27;

    // The ALU uses the opcode value as its operation code, so ADD is shared
    localparam logic [4:0] ALU_ADD = OP_ADD;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    // Instructions grouped by the strobe sequence they need
    typedef enum logic [3:0] {
        C_REG, C_UNARY, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_MULDIV,
        C_JR, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic       pc_out, pc_in, inc_pc, mar_in, md_in, md_out, md_rd, ir_in;
        logic       y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, con_in;
        logic       gra, grb, grc, r_in, r_out, ba_out, c_out, hi_out, lo_out;
        logic [4:0] alu_op;
        logic       mem_read, mem_write;
    } ctrl_t;

    // Map an opcode onto its sequencing class
    function automatic op_class_t decode_op(input logic [4:0] op, input logic has_muldiv);
        op_class_t result;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: result = C_REG;
            OP_NEG, OP_NOT:                 result = C_UNARY;
            OP_ADDI, OP_ANDI, OP_ORI:       result = C_IMM;
            OP_LDI:                         result = C_LDI;
            OP_LD:                          result = C_LD;
            OP_ST:                          result = C_ST;
            OP_BR:                          result = C_BR;
            OP_MUL, OP_DIV:                 result = has_muldiv ? C_MULDIV : C_ILLEGAL;
            OP_JR:                          result = C_JR;
            OP_MFHI:                        result = C_MFHI;
            OP_MFLO:                        result = C_MFLO;
            OP_NOP:                         result = C_NOP;
            OP_HALT:                        result = C_HALT;
            default:                        result = C_ILLEGAL;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/control_sequencer_mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags a timeout on the
// MEM_TIMEOUT-th cycle spent waiting without mem_ready.
module control_sequencer_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);
    localparam logic [3:0] LIMIT = 4'(MEM_TIMEOUT - 1);

    logic [3:0] count;

    // Count unanswered wait cycles; any exit from waiting restarts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 4'd0;
        else if (waiting && !mem_ready && !timeout)
            count <= count + 4'd1;
        else
            count <= 4'd0;
    end

    assign timeout = waiting && !mem_ready && (count == LIMIT);

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer for the 32-bit datapath: fetch (T0-T2), decode
// (T3) and execute (T3-T7), with memory waits bounded by a timeout.
//
// Memory handshake: mem_read / mem_write is held high for every cycle of
// the wait state; the transfer completes at the first rising edge where
// mem_ready is high, and the sequencer advances on that same edge. If
// mem_ready is still low on the MEM_TIMEOUT-th cycle, the request drops at
// that edge, illegal is set and the sequencer halts.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter bit HAS_MULDIV  = 1'b1
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        pc_out, pc_in, inc_pc, mar_in, md_in, md_out, md_rd, ir_in,
    output logic        y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, con_in,
    output logic        gra, grb, grc, r_in, r_out, ba_out, c_out, hi_out, lo_out,
    output logic [4:0]  alu_op,
    output logic        mem_read, mem_write,
    output logic        run,
    output logic        illegal,
    output logic [3:0]  state_dbg
);
    state_t     state;
    logic [4:0] op_q;
    logic       illegal_q;
    logic [4:0] cur_op;
    op_class_t  cls;
    logic       waiting;
    logic       timeout;
    ctrl_t      c;
    logic       unused_ir;

    assign unused_ir = ^ir[26:0];

    // The IR is only valid from T3 on; later phases use the opcode latched at T3
    assign cur_op = (state == S_T3) ? ir[31:27] : op_q;
    assign cls    = decode_op(cur_op, HAS_MULDIV);

    assign waiting = (state == S_T1) || (state == S_T6 && cls == C_LD) ||
                     (state == S_T7 && cls == C_ST);

    control_sequencer_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (clear),
        .waiting   (waiting),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    // State register, opcode latch and sticky illegal flag
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= S_RESET;
            op_q      <= 5'd0;
            illegal_q <= 1'b0;
        end else if (timeout) begin
            state     <= S_HALT;
            illegal_q <= 1'b1;
        end else begin
            case (state)
                S_RESET: state <= S_T0;
                S_T0:    state <= stop ? S_HALT : S_T1;
                S_T1:    if (mem_ready) state <= S_T2;
                S_T2:    state <= S_T3;
                S_T3: begin
                    op_q <= ir[31:27];
                    case (cls)
                        C_JR, C_MFHI, C_MFLO, C_NOP: state <= S_T0;
                        C_HALT:                      state <= S_HALT;
                        C_ILLEGAL: begin state <= S_HALT; illegal_q <= 1'b1; end
                        default:                     state <= S_T4;
                    endcase
                end
                S_T4:    state <= S_T5;
                S_T5:    state <= (cls == C_LD || cls == C_ST || cls == C_BR || cls == C_MULDIV)
                                  ? S_T6 : S_T0;
                S_T6: begin
                    if (cls == C_LD) begin
                        if (mem_ready) state <= S_T7;
                    end else if (cls == C_ST) begin
                        state <= S_T7;
                    end else begin
                        state <= S_T0;
                    end
                end
                S_T7:    if (cls != C_ST || mem_ready) state <= S_T0;
                S_HALT:  state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    // Control word decode from state, opcode class (and stop in T0, con_ff in T6)
    always_comb begin
        c = '0;
        case (state)
            S_T0: if (!stop) begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
            S_T1: begin
                c.zlo_out = 1'b1; c.pc_in = 1'b1; c.mem_read = 1'b1; c.md_rd = 1'b1; c.md_in = 1'b1;
            end
            S_T2: begin c.md_out = 1'b1; c.ir_in = 1'b1; end
            S_T3: case (cls)
                C_REG, C_IMM:       begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
                C_LDI, C_LD, C_ST:  begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
                C_BR:               begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
                C_MULDIV:           begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
                C_JR:               begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
                C_MFHI:             begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                C_MFLO:             begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                default:            ;
            endcase
            S_T4: case (cls)
                C_REG:              begin c.grc = 1'b1; c.r_out = 1'b1; c.alu_op = op_q; c.z_in = 1'b1; end
                C_UNARY, C_MULDIV:  begin c.grb = 1'b1; c.r_out = 1'b1; c.alu_op = op_q; c.z_in = 1'b1; end
                C_IMM:              begin c.c_out = 1'b1; c.alu_op = op_q; c.z_in = 1'b1; end
                C_LDI, C_LD, C_ST:  begin c.c_out = 1'b1; c.alu_op = ALU_ADD; c.z_in = 1'b1; end
                C_BR:               begin c.pc_out = 1'b1; c.y_in = 1'b1; end
                default:            ;
            endcase
            S_T5: case (cls)
                C_REG, C_UNARY, C_IMM, C_LDI: begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                C_LD, C_ST:         begin c.zlo_out = 1'b1; c.mar_in = 1'b1; end
                C_BR:               begin c.c_out = 1'b1; c.alu_op = ALU_ADD; c.z_in = 1'b1; end
                C_MULDIV:           begin c.zlo_out = 1'b1; c.lo_in = 1'b1; end
                default:            ;
            endcase
            S_T6: case (cls)
                C_LD:               begin c.mem_read = 1'b1; c.md_rd = 1'b1; c.md_in = 1'b1; end
                C_ST:               begin c.gra = 1'b1; c.r_out = 1'b1; c.md_in = 1'b1; end
                C_BR:               if (con_ff) begin c.zlo_out = 1'b1; c.pc_in = 1'b1; end
                C_MULDIV:           begin c.zhi_out = 1'b1; c.hi_in = 1'b1; end
                default:            ;
            endcase
            S_T7: case (cls)
                C_LD:               begin c.md_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                C_ST:               c.mem_write = 1'b1;
                default:            ;
            endcase
            default: ;
        endcase
    end

    assign {pc_out, pc_in, inc_pc, mar_in, md_in, md_out, md_rd, ir_in} =
           {c.pc_out, c.pc_in, c.inc_pc, c.mar_in, c.md_in, c.md_out, c.md_rd, c.ir_in};
    assign {y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, con_in} =
           {c.y_in, c.z_in, c.zlo_out, c.zhi_out, c.lo_in, c.hi_in, c.con_in};
    assign {gra, grb, grc, r_in, r_out, ba_out, c_out, hi_out, lo_out} =
           {c.gra, c.grb, c.grc, c.r_in, c.r_out, c.ba_out, c.c_out, c.hi_out, c.lo_out};
    assign alu_op    = c.alu_op;
    assign mem_read  = c.mem_read;
    assign mem_write = c.mem_write;
    assign run       = (state != S_RESET) && (state != S_HALT);
    assign illegal   = illegal_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a per-cycle vector table covering
// each instruction class, plus hand sequences for clear, timeout and stop.
module tb_control_sequencer;

    // Strobe bit positions in the packed comparison vector
    localparam logic [25:0] PC_OUT = 26'd1 << 0,  PC_IN   = 26'd1 << 1,  INC_PC  = 26'd1 << 2,
                            MAR_IN = 26'd1 << 3,  MD_IN   = 26'd1 << 4,  MD_OUT  = 26'd1 << 5,
                            MD_RD  = 26'd1 << 6,  IR_IN   = 26'd1 << 7,  Y_IN    = 26'd1 << 8,
                            Z_IN   = 26'd1 << 9,  ZLO_OUT = 26'd1 << 10, ZHI_OUT = 26'd1 << 11,
                            LO_IN  = 26'd1 << 12, HI_IN   = 26'd1 << 13, CON_IN  = 26'd1 << 14,
                            GRA    = 26'd1 << 15, GRB     = 26'd1 << 16, GRC     = 26'd1 << 17,
                            R_IN   = 26'd1 << 18, R_OUT   = 26'd1 << 19, BA_OUT  = 26'd1 << 20,
                            C_OUT  = 26'd1 << 21, HI_OUT  = 26'd1 << 22, LO_OUT  = 26'd1 << 23,
                            MEM_RD = 26'd1 << 24, MEM_WR  = 26'd1 << 25;
    localparam logic [25:0] F0 = PC_OUT | MAR_IN | INC_PC | Z_IN;
    localparam logic [25:0] F1 = ZLO_OUT | PC_IN | MEM_RD | MD_RD | MD_IN;
    localparam logic [25:0] F2 = MD_OUT | IR_IN;

    localparam logic [31:0] I_LD  = 32'h0000_0000, I_LDI = 32'h0800_0000, I_ST  = 32'h1000_0000,
                            I_ADD = 32'h1891_8000, I_SUB = 32'h2000_0000, I_ANDI = 32'h6800_0000,
                            I_MUL = 32'h8000_0000, I_NEG = 32'h8800_0000, I_BR  = 32'h9800_0000,
                            I_JR  = 32'hA800_0000, I_MFHI = 32'hC800_0000, I_NOP = 32'hD000_0000,
                            I_HALT = 32'hD800_0000, I_BAD = 32'hF800_0000;

    typedef struct {
        logic [31:0] ir;
        logic        ready;
        logic        con;
        logic        stp;
        logic [25:0] exp_s;
        logic [4:0]  exp_alu;
        logic        exp_run;
        logic        exp_ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        clear, con_ff, mem_ready, stop;
    logic [31:0] ir;
    logic        pc_out, pc_in, inc_pc, mar_in, md_in, md_out, md_rd, ir_in;
    logic        y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, con_in;
    logic        gra, grb, grc, r_in, r_out, ba_out, c_out, hi_out, lo_out;
    logic [4:0]  alu_op;
    logic        mem_read, mem_write, run, illegal;
    logic [3:0]  state_dbg;
    logic [25:0] act_s;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    // Clock
    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clear(clear), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready), .stop(stop),
        .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .md_in(md_in),
        .md_out(md_out), .md_rd(md_rd), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .zlo_out(zlo_out), .zhi_out(zhi_out), .lo_in(lo_in), .hi_in(hi_in), .con_in(con_in),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
        .c_out(c_out), .hi_out(hi_out), .lo_out(lo_out), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .run(run), .illegal(illegal),
        .state_dbg(state_dbg)
    );

    assign act_s = {mem_write, mem_read, lo_out, hi_out, c_out, ba_out, r_out, r_in, grc, grb, gra,
                    con_in, hi_in, lo_in, zhi_out, zlo_out, z_in, y_in, ir_in, md_rd, md_out,
                    md_in, mar_in, inc_pc, pc_in, pc_out};

    function automatic vec_t mk(input logic [31:0] i_ir, input logic rdy, input logic con,
                                input logic stp, input logic [25:0] s, input logic [4:0] alu,
                                input logic run_e, input logic ill_e);
        vec_t v;
        v.ir = i_ir; v.ready = rdy; v.con = con; v.stp = stp;
        v.exp_s = s; v.exp_alu = alu; v.exp_run = run_e; v.exp_ill = ill_e;
        return v;
    endfunction

    // Table builders: one row per clock cycle of a running instruction
    task automatic add_row(input logic [31:0] i_ir, input logic rdy, input logic con,
                           input logic stp, input logic [25:0] s, input logic [4:0] alu);
        vecs.push_back(mk(i_ir, rdy, con, stp, s, alu, 1'b1, 1'b0));
    endtask

    task automatic add_fetch(input logic [31:0] i_ir, input int nwait, input logic stp);
        add_row(i_ir, 1'b0, 1'b0, 1'b0, F0, 5'd0);
        for (int k = 0; k < nwait; k++) add_row(i_ir, 1'b0, 1'b0, stp, F1, 5'd0);
        add_row(i_ir, 1'b1, 1'b0, 1'b0, F1, 5'd0);
        add_row(i_ir, 1'b0, 1'b0, 1'b0, F2, 5'd0);
    endtask

    // Driver + checker: drive inputs, let outputs settle, compare
    task automatic apply_check(input vec_t v, input string tag);
        ir = v.ir; mem_ready = v.ready; con_ff = v.con; stop = v.stp;
        #1;
        checks++;
        if ({act_s, alu_op, run, illegal} !== {v.exp_s, v.exp_alu, v.exp_run, v.exp_ill}) begin
            errors++;
            $display("FAIL %s: strobes=%h alu=%0d run=%b illegal=%b state=%0d, expected strobes=%h alu=%0d run=%b illegal=%b",
                     tag, act_s, alu_op, run, illegal, state_dbg, v.exp_s, v.exp_alu, v.exp_run, v.exp_ill);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        apply_check(v, tag);
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic run_fetch(input logic [31:0] i_ir, input string tag);
        run_vec(mk(i_ir, 1'b0, 1'b0, 1'b0, F0, 5'd0, 1'b1, 1'b0), {tag, "_t0"});
        run_vec(mk(i_ir, 1'b1, 1'b0, 1'b0, F1, 5'd0, 1'b1, 1'b0), {tag, "_t1"});
        run_vec(mk(i_ir, 1'b0, 1'b0, 1'b0, F2, 5'd0, 1'b1, 1'b0), {tag, "_t2"});
    endtask

    initial begin
        clear = 1'b1; ir = 32'd0; mem_ready = 1'b0; con_ff = 1'b0; stop = 1'b0;

        // ---- vector table ----
        vecs.push_back(mk(32'd0, 1'b0, 1'b0, 1'b0, 26'd0, 5'd0, 1'b0, 1'b0));   // RESET
        add_fetch(I_ADD, 0, 1'b0);
        add_row(I_ADD, 0, 0, 0, GRB | R_OUT | Y_IN, 5'd0);
        add_row(I_ADD, 0, 0, 0, GRC | R_OUT | Z_IN, 5'd3);
        add_row(I_ADD, 0, 0, 0, ZLO_OUT | GRA | R_IN, 5'd0);
        add_fetch(I_SUB, 2, 1'b1);
        add_row(I_SUB, 0, 0, 0, GRB | R_OUT | Y_IN, 5'd0);
        add_row(I_SUB, 0, 0, 0, GRC | R_OUT | Z_IN, 5'd4);
        add_row(I_SUB, 0, 0, 0, ZLO_OUT | GRA | R_IN, 5'd0);
        add_fetch(I_ANDI, 0, 1'b0);
        add_row(I_ANDI, 0, 0, 0, GRB | R_OUT | Y_IN, 5'd0);
        add_row(I_ANDI, 0, 0, 0, C_OUT | Z_IN, 5'd13);
        add_row(I_ANDI, 0, 0, 0, ZLO_OUT | GRA | R_IN, 5'd0);
        add_fetch(I_LDI, 0, 1'b0);
        add_row(I_LDI, 0, 0, 0, GRB | BA_OUT | Y_IN, 5'd0);
        add_row(I_LDI, 0, 0, 0, C_OUT | Z_IN, 5'd3);
        add_row(I_LDI, 0, 0, 0, ZLO_OUT | GRA | R_IN, 5'd0);
        add_fetch(I_JR, 0, 1'b0);
        add_row(I_JR, 0, 0, 0, GRA | R_OUT | PC_IN, 5'd0);
        add_fetch(I_MFHI, 0, 1'b0);
        add_row(I_MFHI, 0, 0, 0, HI_OUT | GRA | R_IN, 5'd0);
        add_fetch(I_NOP, 0, 1'b0);
        add_row(I_NOP, 0, 0, 0, 26'd0, 5'd0);
        add_fetch(I_MUL, 0, 1'b0);
        add_row(I_MUL, 0, 0, 0, GRA | R_OUT | Y_IN, 5'd0);
        add_row(I_MUL, 0, 0, 0, GRB | R_OUT | Z_IN, 5'd16);
        add_row(I_MUL, 0, 0, 0, ZLO_OUT | LO_IN, 5'd0);
        add_row(I_MUL, 0, 0, 0, ZHI_OUT | HI_IN, 5'd0);
        add_fetch(I_NEG, 0, 1'b0);
        add_row(I_NEG, 0, 0, 0, 26'd0, 5'd0);
        add_row(I_NEG, 0, 0, 0, GRB | R_OUT | Z_IN, 5'd17);
        add_row(I_NEG, 0, 0, 0, ZLO_OUT | GRA | R_IN, 5'd0);
        add_fetch(I_LD, 0, 1'b0);
        add_row(I_LD, 0, 0, 0, GRB | BA_OUT | Y_IN, 5'd0);
        add_row(I_LD, 0, 0, 0, C_OUT | Z_IN, 5'd3);
        add_row(I_LD, 0, 0, 0, ZLO_OUT | MAR_IN, 5'd0);
        for (int k = 0; k < 3; k++) add_row(I_LD, 0, 0, 1, MEM_RD | MD_RD | MD_IN, 5'd0);
        add_row(I_LD, 1, 0, 0, MEM_RD | MD_RD | MD_IN, 5'd0);
        add_row(I_LD, 0, 0, 0, MD_OUT | GRA | R_IN, 5'd0);
        add_fetch(I_ST, 0, 1'b0);
        add_row(I_ST, 0, 0, 0, GRB | BA_OUT | Y_IN, 5'd0);
        add_row(I_ST, 0, 0, 0, C_OUT | Z_IN, 5'd3);
        add_row(I_ST, 0, 0, 0, ZLO_OUT | MAR_IN, 5'd0);
        add_row(I_ST, 0, 0, 0, GRA | R_OUT | MD_IN, 5'd0);
        add_row(I_ST, 0, 0, 0, MEM_WR, 5'd0);
        add_row(I_ST, 1, 0, 0, MEM_WR, 5'd0);
        add_fetch(I_BR, 0, 1'b0);
        add_row(I_BR, 0, 1, 0, GRA | R_OUT | CON_IN, 5'd0);
        add_row(I_BR, 0, 1, 0, PC_OUT | Y_IN, 5'd0);
        add_row(I_BR, 0, 1, 0, C_OUT | Z_IN, 5'd3);
        add_row(I_BR, 0, 0, 0, 26'd0, 5'd0);
        add_fetch(I_BR, 0, 1'b0);
        add_row(I_BR, 0, 0, 0, GRA | R_OUT | CON_IN, 5'd0);
        add_row(I_BR, 0, 0, 0, PC_OUT | Y_IN, 5'd0);
        add_row(I_BR, 0, 0, 0, C_OUT | Z_IN, 5'd3);
        add_row(I_BR, 0, 1, 0, ZLO_OUT | PC_IN, 5'd0);
        add_row(I_NOP, 0, 0, 0, F0, 5'd0);

        repeat (2) @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // ---- clear asserted mid-T4 of add ----
        pulse_clear();
        run_vec(mk(I_ADD, 0, 0, 0, 26'd0, 5'd0, 1'b0, 1'b0), "h1_reset");
        run_fetch(I_ADD, "h1");
        run_vec(mk(I_ADD, 0, 0, 0, GRB | R_OUT | Y_IN, 5'd0, 1'b1, 1'b0), "h1_t3");
        apply_check(mk(I_ADD, 0, 0, 0, GRC | R_OUT | Z_IN, 5'd3, 1'b1, 1'b0), "h1_t4");
        #1 clear = 1'b1;
        apply_check(mk(I_ADD, 0, 0, 0, 26'd0, 5'd0, 1'b0, 1'b0), "h1_async_clear");
        @(negedge clk);
        clear = 1'b0;
        run_vec(mk(I_ADD, 0, 0, 0, 26'd0, 5'd0, 1'b0, 1'b0), "h1_release");
        run_vec(mk(I_ADD, 0, 0, 0, F0, 5'd0, 1'b1, 1'b0), "h1_t0_after");

        // ---- fetch read never answered: timeout after 15 wait cycles ----
        pulse_clear();
        run_vec(mk(I_ADD, 0, 0, 0, 26'd0, 5'd0, 1'b0, 1'b0), "h2_reset");
        run_vec(mk(I_ADD, 0, 0, 0, F0, 5'd0, 1'b1, 1'b0), "h2_t0");
        for (int k = 0; k < 15; k++)
            run_vec(mk(I_ADD, 0, 0, 0, F1, 5'd0, 1'b1, 1'b0), $sformatf("h2_wait%0d", k));
        run_vec(mk(I_ADD, 1, 0, 0, 26'd0, 5'd0, 1'b0, 1'b1), "h2_timeout_halt");
        run_vec(mk(I_ADD, 1, 0, 1, 26'd0, 5'd0, 1'b0, 1'b1), "h2_halt_stays");

        // ---- stop raised in T5 takes effect at the next T0 ----
        pulse_clear();
        run_vec(mk(I_ADD, 0, 0, 0, 26'd0, 5'd0, 1'b0, 1'b0), "h3_reset");
        run_fetch(I_ADD, "h3");
        run_vec(mk(I_ADD, 0, 0, 0, GRB | R_OUT | Y_IN, 5'd0, 1'b1, 1'b0), "h3_t3");
        run_vec(mk(I_ADD, 0, 0, 0, GRC | R_OUT | Z_IN, 5'd3, 1'b1, 1'b0), "h3_t4");
        run_vec(mk(I_ADD, 0, 0, 1, ZLO_OUT | GRA | R_IN, 5'd0, 1'b1, 1'b0), "h3_t5_stop");
        run_vec(mk(I_ADD, 0, 0, 1, 26'd0, 5'd0, 1'b1, 1'b0), "h3_t0_stop");
        run_vec(mk(I_ADD, 1, 0, 0, 26'd0, 5'd0, 1'b0, 1'b0), "h3_halt");

        // ---- halt opcode, with stop raised during its T3 ----
        pulse_clear();
        run_vec(mk(I_HALT, 0, 0, 0, 26'd0, 5'd0, 1'b0, 1'b0), "h4_reset");
        run_fetch(I_HALT, "h4");
        run_vec(mk(I_HALT, 0, 0, 1, 26'd0, 5'd0, 1'b1, 1'b0), "h4_t3");
        run_vec(mk(I_HALT, 1, 0, 0, 26'd0, 5'd0, 1'b0, 1'b0), "h4_halt");

        // ---- unknown opcode 5'b11111 ----
        pulse_clear();
        run_vec(mk(I_BAD, 0, 0, 0, 26'd0, 5'd0, 1'b0, 1'b0), "h5_reset");
        run_fetch(I_BAD, "h5");
        run_vec(mk(I_BAD, 0, 0, 0, 26'd0, 5'd0, 1'b1, 1'b0), "h5_t3");
        run_vec(mk(I_BAD, 1, 0, 0, 26'd0, 5'd0, 1'b0, 1'b1), "h5_halt");
        run_vec(mk(I_BAD, 1, 0, 0, 26'd0, 5'd0, 1'b0, 1'b1), "h5_halt_sticky");

        // ---- report ----
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
